mem_access_controller: RTL and testbench

Initiator side of the main-memory interface: accepts single load/store requests from the KGP-RISC datapath over a valid/ready handshake and drives the main memory's read-enable, write-enable, address and write-data lines. Each access follows a fixed, glitch-free sequence: address/data setup, enable with wait states, then hold. It captures read data and returns it with a one-cycle response pulse. It sits between the execute/memory stage and the main memory module.

---
 rtl/mem_access_controller.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_controller.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_controller.sv
// -----------------------------------------------------------------------------
// mem_access_controller
//
// Initiator side of the KGP-RISC main-memory interface. It accepts one
// load/store request at a time from the execute/memory stage over a
// valid/ready handshake. Each access to main memory then runs through the
// same glitch-free sequence:
//
//   IDLE -> SETUP -> ACCESS (WAIT_CYCLES+1 cycles) -> HOLD -> RESP -> IDLE
//
// Address and write data are presented one cycle before the enable rises.
// They stay put while the enable is high and for one cycle after it falls.
// Load data is captured on the final ACCESS edge and returned with a
// one-cycle resp_valid pulse.
//
// Parameters
//   WAIT_CYCLES       extra cycles the enable is held beyond the first (0..15)
//
// Ports
//   clk               system clock, rising-edge active
//   rst               synchronous, active-high reset
//   req_valid         request present
//   req_write         1 = store, 0 = load
//   req_addr[31:0]    word address, forwarded to memory unchanged
//   req_wdata[31:0]   store data
//   req_ready         high only while IDLE (decoded from state)
//   resp_valid        one-cycle completion pulse
//   resp_rdata[31:0]  load data; 0 after a store
//   mem_address[31:0] address to main memory
//   mem_read_enable   memory read strobe
//   mem_write_enable  memory write strobe
//   mem_data_in[31:0] write data to main memory
//   mem_data_out[31:0] read data from main memory
//
// All outputs except req_ready come straight from flops.
// -----------------------------------------------------------------------------
module mem_access_controller #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_address,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
    S_RESP
  } state_e;

  // The wait counter is 4 bits wide, so it covers the legal range 0..15.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic        resp_valid_q, resp_valid_d;
  logic        accept;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    wait_d  = wait_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        // The address and data registers drive the memory pins directly.
        // Loading them at the accept edge makes them valid for all of SETUP.
        if (accept) begin
          state_d = S_SETUP;
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_write ? req_wdata : '0;
        end
      end

      S_SETUP: begin
        state_d = S_ACCESS;
        wait_d  = WAIT_LOAD;
      end

      S_ACCESS: begin
        if (wait_q == '0) begin
          state_d = S_HOLD;
          // The memory has been enabled for WAIT_CYCLES+1 cycles by this edge.
          // Its read data is valid now.
          rdata_d = write_q ? '0 : mem_data_out;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      S_HOLD: begin
        state_d = S_RESP;
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The enables and resp_valid are registered versions of the state the
    // machine is entering. This keeps them aligned with the state they
    // describe and keeps decode glitches off the memory pins.
    rd_en_d      = (state_d == S_ACCESS) && !write_d;
    wr_en_d      = (state_d == S_ACCESS) &&  write_d;
    resp_valid_d = (state_d == S_RESP);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    // Every flop then samples the pre-edge value of every other flop,
    // whatever order the statements appear in.
    if (rst) begin
      // NOTE: every flop is reset, including the latched request, so a reset
      // mid-access discards it and leaves the memory pins at a known value.
      state_q      <= S_IDLE;
      wait_q       <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign mem_address      = addr_q;
  assign mem_data_in      = wdata_q;
  assign mem_read_enable  = rd_en_q;
  assign mem_write_enable = wr_en_q;
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = rdata_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// -----------------------------------------------------------------------------
// tb_mem_access_controller
//
// Three controllers share one request bus: WAIT_CYCLES = 1 (main), 0 and 15.
// Each controller has its own word-addressed memory, indexed by address[7:0].
// Outputs are sampled 1 time unit after each rising edge.
// Inputs are driven right after that sampling.
// -----------------------------------------------------------------------------
module tb_mem_access_controller;

  localparam int W0 = 1;
  localparam int P0 = W0 + 5;  // IDLE, SETUP, W0+1 ACCESS, HOLD, RESP

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        req_ready    [3];
  logic        resp_valid   [3];
  logic [31:0] resp_rdata   [3];
  logic [31:0] mem_address  [3];
  logic        rd_en        [3];
  logic        wr_en        [3];
  logic [31:0] mem_data_in  [3];
  logic [31:0] mem_data_out [3];

  logic [31:0] mem [3][256];
  logic        mem_init_req;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  mem_access_controller #(.WAIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .mem_address(mem_address[0]), .mem_read_enable(rd_en[0]),
    .mem_write_enable(wr_en[0]), .mem_data_in(mem_data_in[0]),
    .mem_data_out(mem_data_out[0]));

  mem_access_controller #(.WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .mem_address(mem_address[1]), .mem_read_enable(rd_en[1]),
    .mem_write_enable(wr_en[1]), .mem_data_in(mem_data_in[1]),
    .mem_data_out(mem_data_out[1]));

  mem_access_controller #(.WAIT_CYCLES(15)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready[2]),
    .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]),
    .mem_address(mem_address[2]), .mem_read_enable(rd_en[2]),
    .mem_write_enable(wr_en[2]), .mem_data_in(mem_data_in[2]),
    .mem_data_out(mem_data_out[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int a);
    return (a == 32'h10) ? 32'hDEADBEEF : (32'hA500_0000 | 32'(a));
  endfunction

  function automatic int w_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 15);
  endfunction

  // Main memories: asynchronous read, write on the rising edge.
  assign mem_data_out[0] = mem[0][mem_address[0][7:0]];
  assign mem_data_out[1] = mem[1][mem_address[1][7:0]];
  assign mem_data_out[2] = mem[2][mem_address[2][7:0]];

  always @(posedge clk) begin
    if (mem_init_req) begin
      for (int i = 0; i < 3; i++)
        for (int a = 0; a < 256; a++) mem[i][a] = pat(a);
    end else begin
      for (int i = 0; i < 3; i++)
        if (wr_en[i]) mem[i][mem_address[i][7:0]] = mem_data_in[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed single transaction on the W=1 controller.
  // k counts edges after the accept edge E0.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  logic [31:0] last_rdata;

  task automatic do_txn(input vec_t v);
    logic [31:0] exp_din;
    int          en_cnt;
    exp_din   = v.write ? v.wdata : 32'h0;
    en_cnt    = 0;
    req_valid = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    check1("txn_ready_before", req_ready[0], 1'b1);
    tick();                                   // E0
    req_valid = 1'b0;                         // later req_* changes must be ignored
    req_write = ~v.write;
    req_addr  = ~v.addr;
    req_wdata = ~v.wdata;
    for (int k = 0; k <= W0 + 4; k++) begin
      if (k > 0) tick();
      check32("txn_addr", mem_address[0], v.addr);
      check32("txn_data_in", mem_data_in[0], exp_din);
      check1("txn_rd_en", rd_en[0], !v.write && k >= 1 && k <= W0 + 1);
      check1("txn_wr_en", wr_en[0],  v.write && k >= 1 && k <= W0 + 1);
      check1("txn_resp_valid", resp_valid[0], k == W0 + 3);
      check1("txn_ready", req_ready[0], k == W0 + 4);
      if (rd_en[0] || wr_en[0]) en_cnt++;
      if (k == W0 + 3) check32("txn_rdata", resp_rdata[0], v.exp_rdata);
    end
    check32("txn_enable_width", 32'(en_cnt), 32'(W0 + 1));
    last_rdata = v.exp_rdata;
  endtask

  // ---------------------------------------------------------------------------
  // Random-traffic reference: transaction-level timing and a word array
  // ---------------------------------------------------------------------------
  typedef struct {
    int          e0;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic [31:0] model_mem [16];

  vec_t        vecs [6];
  logic [31:0] tp_addr [4];
  logic [31:0] tp_exp  [4];

  initial begin
    int          width  [3];
    int          resp_k [3];
    int          wr_cnt [3];
    logic [31:0] rsp    [3];
    int          resp_cnt;
    int          free_at;
    int          k;
    bit          have;
    txn_t        cur;
    logic [31:0] exp_rd_m;

    vecs[0] = '{1'b1, 32'h20, 32'hCAFEF00D, 32'h0};
    vecs[1] = '{1'b0, 32'h20, 32'h0,        32'hCAFEF00D};
    vecs[2] = '{1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b1, 32'h10, 32'h12345678, 32'h0};
    vecs[4] = '{1'b0, 32'h10, 32'h0,        32'h12345678};
    vecs[5] = '{1'b0, 32'h30, 32'h0,        32'hA5000030};
    tp_addr = '{32'h30, 32'h20, 32'h30, 32'h20};
    tp_exp  = '{32'hA5000030, 32'hCAFEF00D, 32'hA5000030, 32'hCAFEF00D};

    // ---- Reset with req_valid held high --------------------------------------
    rst          = 1'b1;
    mem_init_req = 1'b1;
    req_valid    = 1'b1;
    req_write    = 1'b0;
    req_addr     = 32'h10;
    req_wdata    = 32'h5555AAAA;
    tick();
    mem_init_req = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check1("rst_ready", req_ready[i], 1'b1);
      check1("rst_resp_valid", resp_valid[i], 1'b0);
      check32("rst_rdata", resp_rdata[i], 32'h0);
      check32("rst_addr", mem_address[i], 32'h0);
      check32("rst_data_in", mem_data_in[i], 32'h0);
      check1("rst_rd_en", rd_en[i], 1'b0);
      check1("rst_wr_en", wr_en[i], 1'b0);
    end
    rst       = 1'b0;
    req_valid = 1'b0;
    tick();
    check1("post_rst_ready", req_ready[0], 1'b1);
    check32("post_rst_addr", mem_address[0], 32'h0);
    check1("post_rst_rd_en", rd_en[0], 1'b0);

    // ---- Single load on all three WAIT_CYCLES settings ------------------------
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h10;
    tick();                                   // E0 for all three
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      width[i] = 0; resp_k[i] = -1; wr_cnt[i] = 0; rsp[i] = 32'h0;
    end
    for (int kk = 1; kk <= 24; kk++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        if (rd_en[i]) width[i]++;
        if (wr_en[i]) wr_cnt[i]++;
        if (resp_valid[i] && resp_k[i] < 0) begin
          resp_k[i] = kk;
          rsp[i]    = resp_rdata[i];
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      check32("wsweep_enable_width", 32'(width[i]), 32'(w_of(i) + 1));
      check32("wsweep_resp_latency", 32'(resp_k[i]), 32'(w_of(i) + 3));
      check32("wsweep_rdata", rsp[i], 32'hDEADBEEF);
      check32("wsweep_no_write", 32'(wr_cnt[i]), 32'h0);
    end

    // ---- Table-driven store/load sequence on the W=1 controller ------------
    for (int v = 0; v < 6; v++) do_txn(vecs[v]);

    // ---- Continuous req_valid: one accept per P0 cycles ----------------------
    resp_cnt  = 0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = tp_addr[0];
    check1("tp_ready_start", req_ready[0], 1'b1);
    for (int kk = 0; kk < 4 * P0; kk++) begin
      int j, m;
      tick();
      j = kk / P0;
      m = kk % P0;
      check32("tp_addr", mem_address[0], tp_addr[j]);
      check1("tp_ready", req_ready[0], m == P0 - 1);
      check1("tp_rd_en", rd_en[0], m >= 1 && m <= W0 + 1);
      check1("tp_resp_valid", resp_valid[0], m == W0 + 3);
      if (resp_valid[0]) begin
        resp_cnt++;
        check32("tp_rdata", resp_rdata[0], tp_exp[j]);
      end
      if (m == 0 && j < 3) req_addr = tp_addr[j + 1];
    end
    req_valid = 1'b0;
    check32("tp_resp_count", 32'(resp_cnt), 32'd4);

    // ---- Reset in the second ACCESS cycle of a store ------------------------
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h40;
    req_wdata = 32'h11111111;
    tick();                                   // E0
    req_valid = 1'b0;
    tick();                                   // E1: first ACCESS cycle
    check1("rstmid_wr_en_1", wr_en[0], 1'b1);
    tick();                                   // E2: second ACCESS cycle
    check1("rstmid_wr_en_2", wr_en[0], 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check1("rstmid_wr_en_off", wr_en[0], 1'b0);
    check1("rstmid_rd_en_off", rd_en[0], 1'b0);
    check1("rstmid_ready", req_ready[0], 1'b1);
    check32("rstmid_addr", mem_address[0], 32'h0);
    resp_cnt = 0;
    for (int kk = 0; kk < 6; kk++) begin
      tick();
      if (resp_valid[0] || wr_en[0]) resp_cnt++;
    end
    check32("rstmid_no_resp", 32'(resp_cnt), 32'h0);
    do_txn('{1'b0, 32'h50, 32'h0, 32'hA5000050});

    // ---- Randomized traffic against the reference model ---------------------
    mem_init_req = 1'b1;
    tick();
    mem_init_req = 1'b0;
    for (int a = 0; a < 16; a++) model_mem[a] = pat(a);
    free_at  = cyc + 1;
    have     = 1'b0;
    exp_rd_m = last_rdata;
    cur      = '{0, 1'b0, 32'h0, 32'h0, 32'h0};
    for (int n = 0; n < 600; n++) begin
      bit exp_ready;
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = 1'($urandom_range(0, 1));
      req_addr  = $urandom_range(0, 15);
      req_wdata = $urandom();
      exp_ready = (cyc + 1 >= free_at);
      check1("rnd_ready", req_ready[0], exp_ready);
      if (req_valid && exp_ready) begin
        cur.e0    = cyc + 1;
        cur.write = req_write;
        cur.addr  = req_addr;
        cur.wdata = req_wdata;
        cur.rdata = req_write ? 32'h0 : model_mem[req_addr[3:0]];
        if (req_write) model_mem[req_addr[3:0]] = req_wdata;
        have    = 1'b1;
        free_at = cyc + 1 + P0;
      end
      tick();
      if (have) begin
        k = cyc - cur.e0;
        if (k == W0 + 2) exp_rd_m = cur.rdata;
        check32("rnd_addr", mem_address[0], cur.addr);
        check32("rnd_data_in", mem_data_in[0], cur.write ? cur.wdata : 32'h0);
        check1("rnd_rd_en", rd_en[0], !cur.write && k >= 1 && k <= W0 + 1);
        check1("rnd_wr_en", wr_en[0],  cur.write && k >= 1 && k <= W0 + 1);
        check1("rnd_resp_valid", resp_valid[0], k == W0 + 3);
      end else begin
        check1("rnd_rd_en_idle", rd_en[0], 1'b0);
        check1("rnd_resp_idle", resp_valid[0], 1'b0);
      end
      check32("rnd_rdata", resp_rdata[0], exp_rd_m);
    end
    req_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
